// File: rtl/dmem_responder.sv
// Single-port 32-bit data memory that answers each request after a
// fixed number of wait states. Both sub-word loads and sub-word stores
// are little-endian, and misaligned, out-of-range or illegal accesses
// raise err.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset (memory contents are kept)
//   req    access request, held by the initiator until ready
//   we     1 = store, 0 = load
//   addr   byte address
//   wdata  store data, right-aligned
//   load   000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu (others illegal)
//   store  00 sw, 01 sh, 10 sb (11 illegal)
//   ready  one-cycle response strobe
//   rdata  extended load result, valid while ready=1
//   err    access error, valid while ready=1
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  load,
    input  logic [1:0]  store,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int unsigned IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    localparam logic [2:0] LD_LW  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LHU = 3'b010;
    localparam logic [2:0] LD_LB  = 3'b011;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [1:0] ST_SW  = 2'b00;
    localparam logic [1:0] ST_SH  = 2'b01;
    localparam logic [1:0] ST_SB  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  load_q;
    logic [1:0]  store_q;
    logic        ready_q;
    logic        err_q;
    logic [31:0] rdata_q;

    logic [31:0] mem_q [DEPTH_WORDS];

    // Effective access: live inputs on the sampling edge (needed when
    // WAIT_CYCLES=0 commits on that same edge), latched copy afterwards.
    logic             a_we;
    logic [31:0]      a_addr;
    logic [31:0]      a_wdata;
    logic [2:0]       a_load;
    logic [1:0]       a_store;
    logic             enter_resp_c;
    logic             err_d;
    logic [IDX_W-1:0] idx;
    logic [31:0]      old_word;
    logic [31:0]      wr_bytes;
    logic [3:0]       byte_en;
    logic [31:0]      store_word_d;
    logic [31:0]      load_data_d;
    logic [15:0]      half_sel;
    logic [7:0]       byte_sel;

    // Access decode, error detection, store merge and load extension.
    always_comb begin
        a_we         = we_q;
        a_addr       = addr_q;
        a_wdata      = wdata_q;
        a_load       = load_q;
        a_store      = store_q;
        enter_resp_c = 1'b0;
        err_d        = 1'b0;
        wr_bytes     = 32'd0;
        byte_en      = 4'd0;
        load_data_d  = 32'd0;

        if (state_q == IDLE) begin
            a_we    = we;
            a_addr  = addr;
            a_wdata = wdata;
            a_load  = load;
            a_store = store;
        end

        if (!rst) begin
            if (state_q == IDLE && req && WAIT_INIT == 4'd0) begin
                enter_resp_c = 1'b1;
            end else if (state_q == WAIT && cnt_q == 4'd1) begin
                enter_resp_c = 1'b1;
            end
        end

        if (a_addr[31:2] >= 30'(DEPTH_WORDS)) begin
            err_d = 1'b1;
        end
        if (a_we) begin
            case (a_store)
                ST_SW:   if (a_addr[1:0] != 2'b00) err_d = 1'b1;
                ST_SH:   if (a_addr[0]) err_d = 1'b1;
                ST_SB:   ;
                default: err_d = 1'b1;
            endcase
        end else begin
            case (a_load)
                LD_LW:          if (a_addr[1:0] != 2'b00) err_d = 1'b1;
                LD_LH, LD_LHU:  if (a_addr[0]) err_d = 1'b1;
                LD_LB, LD_LBU:  ;
                default:        err_d = 1'b1;
            endcase
        end

        idx      = a_addr[IDX_W+1:2];
        old_word = mem_q[idx];

        // Replicate store data across lanes; byte enables pick the lanes.
        case (a_store)
            ST_SW: begin
                wr_bytes = a_wdata;
                byte_en  = 4'b1111;
            end
            ST_SH: begin
                wr_bytes = {2{a_wdata[15:0]}};
                byte_en  = a_addr[1] ? 4'b1100 : 4'b0011;
            end
            ST_SB: begin
                wr_bytes = {4{a_wdata[7:0]}};
                byte_en  = 4'(4'b0001 << a_addr[1:0]);
            end
            default: ;
        endcase
        for (int k = 0; k < 4; k++) begin
            store_word_d[8*k +: 8] = byte_en[k] ? wr_bytes[8*k +: 8] : old_word[8*k +: 8];
        end

        half_sel = a_addr[1] ? old_word[31:16] : old_word[15:0];
        byte_sel = old_word[8*a_addr[1:0] +: 8];
        case (a_load)
            LD_LW:   load_data_d = old_word;
            LD_LH:   load_data_d = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  load_data_d = {16'd0, half_sel};
            LD_LB:   load_data_d = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  load_data_d = {24'd0, byte_sel};
            default: load_data_d = 32'd0;
        endcase
    end

    // Memory array: no reset, stores commit on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (enter_resp_c && a_we && !err_d) begin
            mem_q[idx] <= store_word_d;
        end
    end

    // Handshake FSM with registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            load_q  <= 3'd0;
            store_q <= 2'd0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        load_q  <= load;
                        store_q <= store;
                        cnt_q   <= WAIT_INIT;
                        state_q <= (WAIT_INIT == 4'd0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= RESP;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            if (enter_resp_c) begin
                ready_q <= 1'b1;
                err_q   <= err_d;
                if (err_d) begin
                    rdata_q <= 32'd0;
                end else if (!a_we) begin
                    rdata_q <= load_data_d;
                end
            end
        end
    end

    assign ready = ready_q;
    assign err   = err_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance driven from
// a vector table plus reset/timing sequences, and a WAIT_CYCLES=0 instance
// with a small depth for zero-wait latency and range checks.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        req0;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  load;
    logic [1:0]  store;
    logic        ready, ready0;
    logic [31:0] rdata, rdata0;
    logic        err, err0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .load(load), .store(store), .ready(ready), .rdata(rdata), .err(err)
    );

    dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .req(req0), .we(we), .addr(addr), .wdata(wdata),
        .load(load), .store(store), .ready(ready0), .rdata(rdata0), .err(err0)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  load;
        logic [1:0]  store;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [2:0] ld, input logic [1:0] st,
                                input logic c, input logic [31:0] r, input logic e);
        vec_t v;
        v.we = w; v.addr = a; v.wdata = d; v.load = ld; v.store = st;
        v.chk_rd = c; v.exp_rd = r; v.exp_err = e;
        return v;
    endfunction

    // Issue one access and hold req until ready; lat counts negedges from
    // the sampling edge to the ready cycle (99 if ready never arrives).
    task automatic do_access(input bit sel, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [2:0] ld, input logic [1:0] st,
                             output int lat, output logic [31:0] rd, output logic e);
        @(negedge clk);
        we = w; addr = a; wdata = d; load = ld; store = st;
        if (sel) req0 = 1'b1; else req = 1'b1;
        lat = 99; rd = 32'hx; e = 1'bx;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (sel ? ready0 : ready) begin
                lat = i;
                rd  = sel ? rdata0 : rdata;
                e   = sel ? err0 : err;
                break;
            end
        end
        req = 1'b0; req0 = 1'b0;
    endtask

    task automatic access_check(input string name, input bit sel, input vec_t v, input int exp_lat);
        int          lat;
        logic [31:0] rd;
        logic        e;
        do_access(sel, v.we, v.addr, v.wdata, v.load, v.store, lat, rd, e);
        check({name, "_lat"}, 32'(lat), 32'(exp_lat));
        check({name, "_err"}, {31'd0, e}, {31'd0, v.exp_err});
        if (v.chk_rd) check({name, "_rdata"}, rd, v.exp_rd);
        @(negedge clk);
        check({name, "_ready_drop"}, {31'd0, sel ? ready0 : ready}, 32'd0);
        check({name, "_err_drop"},   {31'd0, sel ? err0 : err},     32'd0);
    endtask

    initial begin
        int          lat;
        int          last;
        int          cnt;
        bit          seen;
        logic [31:0] rd;
        logic        e;

        rst = 1'b1; req = 1'b0; req0 = 1'b0; we = 1'b0;
        addr = 32'd0; wdata = 32'd0; load = 3'd0; store = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_ready",  {31'd0, ready},  32'd0);
        check("rst_err",    {31'd0, err},    32'd0);
        check("rst_rdata",  rdata,           32'd0);
        check("rst_ready0", {31'd0, ready0}, 32'd0);
        check("rst_rdata0", rdata0,          32'd0);
        rst = 1'b0;

        //             we    addr          wdata         load    store  chk   exp_rd        err
        vecs.push_back(mk(1, 32'h10,  32'hDEADBEEF, 3'b000, 2'b00, 0, 32'h0,        0));
        vecs.push_back(mk(0, 32'h10,  32'h0,        3'b000, 2'b00, 1, 32'hDEADBEEF, 0));
        vecs.push_back(mk(1, 32'h20,  32'h0,        3'b000, 2'b00, 0, 32'h0,        0));
        vecs.push_back(mk(1, 32'h21,  32'h81,       3'b000, 2'b10, 0, 32'h0,        0));
        vecs.push_back(mk(0, 32'h21,  32'h0,        3'b011, 2'b00, 1, 32'hFFFFFF81, 0));
        vecs.push_back(mk(0, 32'h21,  32'h0,        3'b100, 2'b00, 1, 32'h00000081, 0));
        vecs.push_back(mk(0, 32'h20,  32'h0,        3'b000, 2'b00, 1, 32'h00008100, 0));
        vecs.push_back(mk(1, 32'h22,  32'h8001,     3'b000, 2'b01, 0, 32'h0,        0));
        vecs.push_back(mk(0, 32'h22,  32'h0,        3'b001, 2'b00, 1, 32'hFFFF8001, 0));
        vecs.push_back(mk(0, 32'h22,  32'h0,        3'b010, 2'b00, 1, 32'h00008001, 0));
        vecs.push_back(mk(0, 32'h20,  32'h0,        3'b000, 2'b00, 1, 32'h80018100, 0));
        vecs.push_back(mk(0, 32'h23,  32'h0,        3'b011, 2'b00, 1, 32'hFFFFFF80, 0));
        vecs.push_back(mk(0, 32'h20,  32'h0,        3'b100, 2'b00, 1, 32'h00000000, 0));
        vecs.push_back(mk(0, 32'h20,  32'h0,        3'b001, 2'b00, 1, 32'hFFFF8100, 0));
        vecs.push_back(mk(0, 32'h13,  32'h0,        3'b000, 2'b00, 1, 32'h0,        1));
        vecs.push_back(mk(1, 32'h21,  32'hFFFF,     3'b000, 2'b01, 1, 32'h0,        1));
        vecs.push_back(mk(0, 32'h20,  32'h0,        3'b000, 2'b00, 1, 32'h80018100, 0));
        vecs.push_back(mk(0, 32'h400, 32'h0,        3'b000, 2'b00, 1, 32'h0,        1));
        vecs.push_back(mk(0, 32'h20,  32'h0,        3'b111, 2'b00, 1, 32'h0,        1));
        vecs.push_back(mk(1, 32'h20,  32'h0,        3'b000, 2'b11, 1, 32'h0,        1));
        vecs.push_back(mk(0, 32'h20,  32'h0,        3'b000, 2'b00, 1, 32'h80018100, 0));
        vecs.push_back(mk(1, 32'h3FC, 32'hAAAA5555, 3'b000, 2'b00, 0, 32'h0,        0));
        vecs.push_back(mk(0, 32'h3FC, 32'h0,        3'b000, 2'b00, 1, 32'hAAAA5555, 0));
        vecs.push_back(mk(1, 32'h40,  32'h11111111, 3'b000, 2'b00, 0, 32'h0,        0));

        for (int i = 0; i < vecs.size(); i++) begin
            access_check($sformatf("vec%0d", i), 1'b0, vecs[i], 3);
        end

        // Reset while the store to 0x40 is in WAIT: no response, no write.
        @(negedge clk);
        we = 1'b1; addr = 32'h40; wdata = 32'h12345678; load = 3'd0; store = 2'b00; req = 1'b1;
        @(negedge clk);
        rst = 1'b1; req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ready) seen = 1'b1;
        end
        check("abort_no_ready", {31'd0, seen}, 32'd0);
        check("abort_rdata_rst", rdata, 32'd0);
        access_check("abort_reload", 1'b0, mk(0, 32'h40, 32'h0, 3'b000, 2'b00, 1, 32'h11111111, 0), 3);

        // A request coincident with reset is dropped.
        @(negedge clk);
        rst = 1'b1; req = 1'b1; we = 1'b1; addr = 32'h40; wdata = 32'h00000BAD; store = 2'b00;
        @(negedge clk);
        rst = 1'b0; req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ready) seen = 1'b1;
        end
        check("rstreq_no_ready", {31'd0, seen}, 32'd0);
        access_check("rstreq_reload", 1'b0, mk(0, 32'h40, 32'h0, 3'b000, 2'b00, 1, 32'h11111111, 0), 3);

        // Inputs scrambled during WAIT must not change the load of 0x10.
        @(negedge clk);
        we = 1'b0; addr = 32'h10; load = 3'b000; store = 2'b00; req = 1'b1;
        @(negedge clk);
        we = 1'b1; addr = 32'h21; load = 3'b011; store = 2'b10; wdata = 32'h55;
        lat = 99;
        for (int i = 2; i <= 20; i++) begin
            if (ready) begin
                lat = i - 1;
                rd  = rdata;
                e   = err;
                break;
            end
            @(negedge clk);
        end
        req = 1'b0;
        check("scramble_lat",   32'(lat), 32'd3);
        check("scramble_rdata", rd,       32'hDEADBEEF);
        check("scramble_err",   {31'd0, e}, 32'd0);
        access_check("scramble_mem", 1'b0, mk(0, 32'h20, 32'h0, 3'b000, 2'b00, 1, 32'h80018100, 0), 3);

        // Continuous req: one response every WAIT_CYCLES+2 = 4 cycles.
        @(negedge clk);
        we = 1'b0; addr = 32'h10; load = 3'b000; req = 1'b1;
        last = 0; cnt = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (ready) begin
                if (last != 0) check("stream_gap", 32'(i - last), 32'd4);
                last = i;
                cnt++;
            end
        end
        req = 1'b0;
        check("stream_count", 32'(cnt), 32'd4);
        repeat (6) @(negedge clk);

        // Zero-wait instance: ready in the cycle after the sampling edge.
        access_check("w0_sw", 1'b1, mk(1, 32'h8,  32'hCAFEF00D, 3'b000, 2'b00, 0, 32'h0,        0), 1);
        access_check("w0_lw", 1'b1, mk(0, 32'h8,  32'h0,        3'b000, 2'b00, 1, 32'hCAFEF00D, 0), 1);
        access_check("w0_sb", 1'b1, mk(1, 32'hA,  32'h7F,       3'b000, 2'b10, 0, 32'h0,        0), 1);
        access_check("w0_lw2",1'b1, mk(0, 32'h8,  32'h0,        3'b000, 2'b00, 1, 32'hCA7FF00D, 0), 1);
        access_check("w0_oob",1'b1, mk(0, 32'h40, 32'h0,        3'b000, 2'b00, 1, 32'h0,        1), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
